// File: rtl/uart_tx_scheduler_pkg.sv
// Shared constants for the UART transmit scheduler: baud/parity codes, clocks-per-bit
// for a 1.8432 MHz transmitter clock, frame timing helpers and scheduler state codes.
package uart_tx_scheduler_pkg;

    localparam logic [2:0] BAUD_1200   = 3'd0;
    localparam logic [2:0] BAUD_2400   = 3'd1;
    localparam logic [2:0] BAUD_4800   = 3'd2;
    localparam logic [2:0] BAUD_9600   = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;
    localparam logic [2:0] BAUD_SLOWEST = BAUD_1200;
    localparam logic [2:0] BAUD_NORMAL  = BAUD_9600;
    localparam logic [2:0] BAUD_FASTEST = BAUD_115200;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    localparam int CPB_1200   = 1536;
    localparam int CPB_2400   = 768;
    localparam int CPB_4800   = 384;
    localparam int CPB_9600   = 192;
    localparam int CPB_115200 = 16;

    localparam int FRAME_BITS   = 10;
    localparam int FRAME_PAD    = 2;   // transmitter's waiting-state latency
    localparam int SETUP_CYCLES = 2;
    localparam int MAX_FRAME    = FRAME_BITS * CPB_1200 + FRAME_PAD;
    localparam int TIMER_W      = $clog2(MAX_FRAME + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_SEND,
        S_GAP
    } schedState_t;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] baud;
        logic [1:0] parity;
    } txCfg_t;

    function automatic logic [2:0] sanitizeBaud(input logic [2:0] code);
        return (code > BAUD_115200) ? BAUD_NORMAL : code;
    endfunction

    function automatic logic [TIMER_W-1:0] frameCycles(input logic [2:0] code);
        int cpb;
        case (code)
            BAUD_1200:   cpb = CPB_1200;
            BAUD_2400:   cpb = CPB_2400;
            BAUD_4800:   cpb = CPB_4800;
            BAUD_115200: cpb = CPB_115200;
            default:     cpb = CPB_9600;
        endcase
        return TIMER_W'(FRAME_BITS * cpb + FRAME_PAD);
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter_pick.sv
// Combinational round-robin find-first: lowest index at or above rrPtr wins,
// otherwise the lowest index below it.
module rr_arbiter_pick #(
    parameter int NUM_REQ = 4,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] reqValid,
    input  logic [PW-1:0]      rrPtr,
    output logic [PW-1:0]      grant,
    output logic               anyValid
);

    always_comb begin
        grant    = '0;
        anyValid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!anyValid && reqValid[i] && (PW'(i) >= rrPtr)) begin
                anyValid = 1'b1;
                grant    = PW'(i);
            end
        end
        // wrap-around pass: only reached when nothing at or above rrPtr is pending
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!anyValid && reqValid[i]) begin
                anyValid = 1'b1;
                grant    = PW'(i);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte requesters.
// Optional UART_TX_SCHED_STATS_EN adds frameCount / lastGrant outputs.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int GUARD_CYCLES = 4,
    parameter int START_HOLD   = 2
) (
    input  logic                 clkTx,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   reqValid,
    input  logic [NUM_REQ*8-1:0] reqData,
    output logic [NUM_REQ-1:0]   reqAck,
    input  logic [2:0]           baudSel,
    input  logic [1:0]           paritySel,
    output logic [7:0]           txData,
    output logic                 txStart,
    output logic [2:0]           txBaud,
    output logic [1:0]           txParity,
    output logic                 busy
`ifdef UART_TX_SCHED_STATS_EN
    ,
    output logic [15:0]          frameCount,
    output logic [2:0]           lastGrant
`endif
);

    localparam int PW = $clog2(NUM_REQ);

    schedState_t               state;
    logic [PW-1:0]             rrPtr;
    logic [PW-1:0]             grant;
    logic                      anyValid;
    logic [TIMER_W-1:0]        timer;
    logic [TIMER_W-1:0]        frameLen;
    logic                      sendDone;
    txCfg_t                    cfg;
    logic [NUM_REQ-1:0][7:0]   reqBytes;

    assign reqBytes = reqData;
    assign frameLen = frameCycles(cfg.baud);
    assign sendDone = (timer == frameLen - 1'b1);

    assign txData   = cfg.data;
    assign txBaud   = cfg.baud;
    assign txParity = cfg.parity;

    rr_arbiter_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) uPick (
        .reqValid (reqValid),
        .rrPtr    (rrPtr),
        .grant    (grant),
        .anyValid (anyValid)
    );

    always_ff @(posedge clkTx or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            rrPtr   <= '0;
            timer   <= '0;
            cfg     <= '{data: 8'h00, baud: BAUD_NORMAL, parity: PAR_NONE};
            txStart <= 1'b0;
            reqAck  <= '0;
            busy    <= 1'b0;
        end else begin
            reqAck <= '0;
            unique case (state)
                S_IDLE: begin
                    // grant is registered here so ack and latched byte are visible in LOAD
                    if (anyValid) begin
                        state  <= S_LOAD;
                        busy   <= 1'b1;
                        cfg    <= '{data: reqBytes[grant], baud: sanitizeBaud(baudSel),
                                    parity: paritySel};
                        reqAck <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant;
                        rrPtr  <= (grant == PW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                    end
                end
                S_LOAD: begin
                    state <= S_SETUP;
                    timer <= '0;
                end
                S_SETUP: begin
                    if (timer == TIMER_W'(SETUP_CYCLES - 1)) begin
                        state   <= S_SEND;
                        timer   <= '0;
                        txStart <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_SEND: begin
                    if (sendDone) begin
                        state   <= S_GAP;
                        timer   <= '0;
                        txStart <= 1'b0;
                    end else begin
                        timer   <= timer + 1'b1;
                        txStart <= (timer < TIMER_W'(START_HOLD - 1));
                    end
                end
                S_GAP: begin
                    if (timer == TIMER_W'(GUARD_CYCLES - 1)) begin
                        state <= S_IDLE;
                        timer <= '0;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef UART_TX_SCHED_STATS_EN
    always_ff @(posedge clkTx or posedge reset) begin
        if (reset) begin
            frameCount <= '0;
            lastGrant  <= '0;
        end else begin
            if (state == S_IDLE && anyValid)
                lastGrant <= 3'(grant);
            if (state == S_SEND && sendDone)
                frameCount <= frameCount + 16'd1;
        end
    end
`endif

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Round-robin scheduler sharing one UART transmitter among NUM_REQ byte requesters.
- Drives the transmitter's data, start, baud-select and parity-select inputs.
- The transmitter has no busy/done output, so the scheduler times each frame itself from the shared baud constants.
- Sits between the byte producers and the transmitter, on the transmitter's clock.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GUARD_CYCLES, 4, idle cycles appended after every frame before the next grant.
- START_HOLD, 2, cycles txStart is held high per frame.

Ports:
- clkTx  in  1  transmitter clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- reqValid  in  NUM_REQ  per-requester byte pending.
- reqData  in  NUM_REQ*8  flattened bytes; requester i uses bits [8i+7:8i].
- reqAck  out  NUM_REQ  one-cycle pulse: requester's byte accepted.
- baudSel  in  3  baud code from the shared package (slowest..fastest).
- paritySel  in  2  parity code from the shared package (noParity/oddParity/evenParity).
- txData  out  8  byte to transmitter.
- txStart  out  1  start strobe to transmitter.
- txBaud  out  3  baud code to transmitter.
- txParity  out  2  parity code to transmitter.
- busy  out  1  high from LOAD through end of GAP.

Behaviour:
- Reset (async, immediate):
  - state IDLE; rrPtr=0; txStart=0; txData=0; reqAck=0; busy=0.
  - txBaud=`normal; txParity=`noParity.
  - The transmitter is not reset by this block.
- States:
  - IDLE: if any reqValid, go to LOAD; otherwise stay.
  - LOAD (1 cycle):
    - Grant g = first i with reqValid[i], searching from rrPtr upward, modulo NUM_REQ.
    - Latch txData=reqData[g], txBaud=baudSel, txParity=paritySel.
    - Pulse reqAck[g]=1; rrPtr<=(g+1) mod NUM_REQ; go to SETUP.
  - SETUP (2 cycles): outputs stable; this covers the transmitter's one-cycle config register and its clocksPerBit decode. Then go to SEND.
  - SEND:
    - txStart=1 for the first START_HOLD cycles, then 0.
    - frame timer counts FRAME = 10*cpb + 2 cycles, where cpb is the package clocks-per-bit constant for the latched txBaud (+2 covers the transmitter's waiting-state latency). Then go to GAP.
  - GAP: GUARD_CYCLES cycles, then IDLE; txBaud/txParity/txData keep their values.
- Arbitration and handshake:
  - Evaluated only in IDLE→LOAD; requests arriving during busy wait.
  - A requester must hold reqValid and reqData stable until reqAck.
  - Deasserting reqValid before ack withdraws the request without error.
  - reqValid sampled high in the same cycle as its reqAck is a new request for a later frame.
- Invalid baudSel (5..7): txBaud forced to `normal and the frame is timed at `_9600.
- baudSel/paritySel changes mid-frame are ignored until the next LOAD.
- Latency: reqValid high in IDLE → reqAck next edge → txStart high 3 cycles after reqAck.
- Back-to-back frames: the next LOAD occurs one cycle after GAP ends.
- Frame timer width ≥ ceil(log2(10*`_1200+2)); no wrap within a frame.
- Reset mid-SEND aborts immediately; the transmitter may finish its frame, and software must allow one slowest frame before reuse.

Optional Feature:
- Macro UART_TX_SCHED_STATS_EN.
- When defined: extra outputs frameCount (16-bit) and lastGrant (3-bit).
  - frameCount increments at each SEND→GAP and wraps 0xFFFF→0.
  - lastGrant holds g from the latest LOAD.
  - Both reset to 0.
- When undefined: the ports and logic are absent, with no other behavioural change.

Decomposition:
- Shared package (parameters.v): baud codes, parity codes, clocks-per-bit constants `_1200..`_115200, new scheduler state codes, and FRAME_BITS=10.
- One sub-module, rr_arbiter_pick: combinational round-robin find-first (reqValid, rrPtr → grant index, anyValid).

Test Plan:
- Single request: reqValid[2]=1, reqData=0xA5, baudSel=`fastest, noParity → reqAck[2] one cycle; txData=0xA5; txStart high exactly 2 cycles, 3 cycles after ack; busy low after 3+10*`_115200+2+GUARD_CYCLES cycles.
- All four requesting, rrPtr=0 → acks in order 0,1,2,3,0; each frame separated by the full frame + guard time.
- Invalid baudSel=6 → txBaud=`normal; SEND lasts 10*`_9600+2 cycles.
- baudSel changed `fastest→`slowest mid-SEND → current frame keeps `fastest timing; next frame uses `slowest.
- reset asserted mid-SEND → same-cycle txStart=0, busy=0, rrPtr=0; after release, pending reqValid[1] is granted first.
- With UART_TX_SCHED_STATS_EN: after 3 frames frameCount=3 and lastGrant=the third grant index; preload/force 0xFFFF → wraps to 0.
